// File: rtl/sipo_in_pkg.sv
// sipo_in_pkg: shared defaults and state encoding for the NPU serial-in/parallel-out stage
package sipo_in_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_NUM_TAPS = 4;
  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} sipo_state_e;
endpackage

// File: rtl/sipo_in.sv
// sipo_in: double-buffered serial-in/parallel-out stage assembling NUM_TAPS words into one held vector
module sipo_in
  import sipo_in_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  localparam int CW = $clog2(NUM_TAPS)
) (
  input  logic                      CLKEXT,
  input  logic                      CLR_SIPO_IN_N,
  input  logic                      EN_SIPO_IN,
  input  logic [WIDTH-1:0]          DATA_IN,
  output logic                      READY_IN,
  input  logic                      ACK_SIPO_IN,
  output logic [WIDTH*NUM_TAPS-1:0] DATA_OUT,
  output logic                      FULL_OUT,
  output logic [CW-1:0]             COUNT_OUT
);
  sipo_state_e state, state_nxt;
  logic [WIDTH*NUM_TAPS-1:0] fill, fill_nxt;
  logic last, acc, done;
  assign last = COUNT_OUT == CW'(NUM_TAPS - 1);
  assign FULL_OUT = state == HELD;
  assign READY_IN = ~(FULL_OUT & ~ACK_SIPO_IN & last);
  assign acc = EN_SIPO_IN & READY_IN;
  assign done = acc & last;
  // merge the accepted word into its slot; first word lands in the top slice
  always_comb begin
    fill_nxt = fill;
    if (acc) fill_nxt[WIDTH*(NUM_TAPS-int'(COUNT_OUT))-1 -: WIDTH] = DATA_IN;
  end
  // a completion always (re)fills the output; ACK only empties it when nothing new arrives
  always_comb begin
    state_nxt = done ? HELD : (FULL_OUT && ACK_SIPO_IN) ? EMPTY : state;
  end
  // fill buffer, tap counter, output register and FULL state
  always_ff @(posedge CLKEXT) begin
    if (!CLR_SIPO_IN_N) begin
      state <= EMPTY;
      fill <= '0;
      DATA_OUT <= '0;
      COUNT_OUT <= '0;
    end else begin
      state <= state_nxt;
      fill <= fill_nxt;
      if (done) DATA_OUT <= fill_nxt;
      if (acc) COUNT_OUT <= last ? '0 : COUNT_OUT + 1'b1;
    end
  end
endmodule
